avmm_pr_freeze_bridge: RTL and testbench

AVMM_PR_FREEZE_BRIDGE -- requirements
Module: avmm_pr_freeze_bridge

---
 rtl/avmm_pr_freeze_bridge.sv | 114 +++++++++++
 tb/tb_avmm_pr_freeze_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_pr_freeze_bridge.sv
// Avalon-MM bridge between a partial-reconfiguration region and the static fabric.
// It holds one command at a time, tracks outstanding reads, and isolates the region on freeze request.
module avmm_pr_freeze_bridge #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [DATA_W-1:0] s_writedata,
  input  logic              s_write,
  input  logic              s_read,
  output logic              s_waitrequest,
  output logic [DATA_W-1:0] s_readdata,
  output logic              s_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_write,
  output logic              m_read,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  input  logic              freeze_req,
  output logic              freeze_ack,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, FROZEN} state_t;

  localparam logic [3:0] PEND_MAX = 4'(MAX_PENDING);

  state_t            state, state_nxt;
  logic              cmd_valid, cmd_is_read;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [3:0]        pending, pending_nxt;
  logic [7:0]        err;
  logic [8:0]        err_sum;
  logic [1:0]        err_inc;
  logic              rdv;
  logic [DATA_W-1:0] rdata;
  logic              both, accept, issue, rd_issue, rsp_ok, rsp_bad;

  always_comb begin
    s_waitrequest = ~rst | (state != RUN) | cmd_valid | (pending == PEND_MAX);
    both          = (state == RUN) & s_read & s_write;
    accept        = (state == RUN) & (s_read ^ s_write) & ~s_waitrequest;
    issue         = cmd_valid & ~m_waitrequest;
    rd_issue      = issue & cmd_is_read;
    rsp_ok        = m_readdatavalid & (pending != '0);
    rsp_bad       = m_readdatavalid & (pending == '0);
    // A rejected dual strobe and a spurious response can land in the same cycle.
    err_inc       = {1'b0, both} + {1'b0, rsp_bad};
    err_sum       = {1'b0, err} + {7'b0, err_inc};
  end

  always_comb begin
    pending_nxt = pending;
    unique case ({rd_issue, rsp_ok})
      2'b10:   pending_nxt = pending + 4'd1;
      2'b01:   pending_nxt = pending - 4'd1;
      default: pending_nxt = pending;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (freeze_req) state_nxt = DRAIN;
      DRAIN:   if (!cmd_valid && (pending == '0)) state_nxt = FROZEN;
      FROZEN:  if (!freeze_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      cmd_valid   <= 1'b0;
      cmd_is_read <= 1'b0;
      cmd_addr    <= '0;
      cmd_data    <= '0;
      pending     <= '0;
      err         <= '0;
      rdv         <= 1'b0;
      rdata       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_valid   <= 1'b1;
        cmd_is_read <= s_read;
        cmd_addr    <= s_address;
        cmd_data    <= s_writedata;
      end else if (issue) begin
        cmd_valid <= 1'b0;
      end
      pending <= pending_nxt;
      err     <= err_sum[8] ? 8'hFF : err_sum[7:0];
      rdv     <= rsp_ok;
      if (rsp_ok) rdata <= m_readdata;
    end
  end

  assign m_read          = cmd_valid & cmd_is_read;
  assign m_write         = cmd_valid & ~cmd_is_read;
  assign m_address       = cmd_addr;
  assign m_writedata     = cmd_data;
  assign s_readdata      = rdata;
  assign s_readdatavalid = rdv;
  assign freeze_ack      = (state == FROZEN);
  assign err_cnt         = err;

endmodule

// File: tb/tb_avmm_pr_freeze_bridge.sv
// Scoreboard bench for avmm_pr_freeze_bridge: directed stimulus pushes expectations,
// a downstream slave model returns delayed reads, and a monitor pops and compares.
module tb_avmm_pr_freeze_bridge;

  logic        clk, rst;
  logic [19:0] s_address;
  logic [31:0] s_writedata;
  logic        s_write, s_read, s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic [19:0] m_address;
  logic [31:0] m_writedata;
  logic        m_write, m_read, m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic        freeze_req, freeze_ack;
  logic [7:0]  err_cnt;

  avmm_pr_freeze_bridge #(.ADDR_W(20), .DATA_W(32), .MAX_PENDING(4)) dut (
    .clk(clk), .rst(rst),
    .s_address(s_address), .s_writedata(s_writedata), .s_write(s_write), .s_read(s_read),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_writedata(m_writedata), .m_write(m_write), .m_read(m_read),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .freeze_req(freeze_req), .freeze_ack(freeze_ack), .err_cnt(err_cnt)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rsp_delay = 4;
  int          model_pend = 0;
  int          max_pend = 0;
  int          last_rdv_cyc = 0;
  bit          ret_ok = 0;
  bit          stray = 0;
  rsp_t        sq[$];
  logic [31:0] rd_exp[$];
  logic [51:0] wr_exp[$];

  logic [19:0] rd_addr[5] = '{20'h00100, 20'h00204, 20'h3FF08, 20'hFFFFC, 20'h00000};
  logic [31:0] rd_data[5] = '{32'hC5A00100, 32'hC5A00204, 32'hC5A3FF08, 32'hC5AFFFFC, 32'hC5A00000};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Downstream slave: returns each read rsp_delay windows after it issues.
  initial begin
    rsp_t        r;
    logic        rdv;
    logic [31:0] d;
    bit          iss;
    m_readdatavalid = 0;
    m_readdata      = '0;
    forever begin
      @(negedge clk); #2;
      cyc++;
      rdv = 0;
      d   = '0;
      if (stray) begin
        rdv   = 1;
        d     = 32'hBAD0BAD0;
        stray = 0;
      end else if (sq.size() > 0 && sq[0].due <= cyc) begin
        rdv = 1;
        d   = sq[0].data;
        void'(sq.pop_front());
      end
      m_readdatavalid = rdv;
      m_readdata      = d;
      iss = m_read && !m_waitrequest;
      if (iss) begin
        r.due  = cyc + rsp_delay;
        r.data = {12'hC5A, m_address};
        sq.push_back(r);
      end
      if (!rst) begin
        model_pend = 0;
        ret_ok     = 0;
      end else begin
        ret_ok     = rdv && (model_pend > 0);
        model_pend = model_pend + int'(iss) - int'(ret_ok);
        if (model_pend > max_pend) max_pend = model_pend;
        if (rdv) last_rdv_cyc = cyc;
      end
    end
  end

  // Monitor: compares upstream read returns and downstream write issues.
  initial begin
    bit          mon_prev = 0;
    logic [31:0] e;
    logic [51:0] w;
    forever begin
      @(negedge clk); #3;
      if (!rst) begin
        mon_prev = 0;
      end else begin
        if (s_readdatavalid || mon_prev) chk("rdv_latency", s_readdatavalid, mon_prev);
        if (s_readdatavalid) begin
          chk("rd_queue_nonempty", rd_exp.size() != 0, 1);
          if (rd_exp.size() != 0) begin
            e = rd_exp.pop_front();
            chk("rd_data", s_readdata, e);
          end
        end
        if (m_write && !m_waitrequest) begin
          chk("wr_queue_nonempty", wr_exp.size() != 0, 1);
          if (wr_exp.size() != 0) begin
            w = wr_exp.pop_front();
            chk("wr_cmd", {m_address, m_writedata}, w);
          end
        end
        mon_prev = ret_ok;
      end
    end
  end

  task automatic cmd(input bit rd, input logic [19:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input bit stall);
    int n = 0;
    @(negedge clk);
    while (s_waitrequest && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n < 200, 1);
    s_address   = a;
    s_writedata = d;
    s_read      = rd;
    s_write     = !rd;
    if (stall) m_waitrequest = 1;
    if (rd) rd_exp.push_back(exp);
    else    wr_exp.push_back({a, d});
    @(negedge clk);
    s_read  = 0;
    s_write = 0;
    chk(rd ? "issue_lat_read" : "issue_lat_write", rd ? m_read : m_write, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sq.size() > 0 || rd_exp.size() > 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 300, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (!freeze_ack && n < 100) begin
      @(negedge clk); #4;
      n++;
    end
    chk(name, n < 100, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_swait"}, s_waitrequest, 1);
    chk({tag, "_mread"}, m_read, 0);
    chk({tag, "_mwrite"}, m_write, 0);
    chk({tag, "_maddr"}, m_address, 0);
    chk({tag, "_mwdata"}, m_writedata, 0);
    chk({tag, "_srdv"}, s_readdatavalid, 0);
    chk({tag, "_srdata"}, s_readdata, 0);
    chk({tag, "_ack"}, freeze_ack, 0);
    chk({tag, "_err"}, err_cnt, 0);
  endtask

  initial begin
    int act_cnt;
    rst = 0; s_address = '0; s_writedata = '0; s_read = 0; s_write = 0;
    m_waitrequest = 0; freeze_req = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1;
    @(negedge clk);
    chk("idle_swait", s_waitrequest, 0);

    // Write stalled downstream for 3 cycles.
    @(negedge clk);
    s_write = 1; s_address = 20'h00010; s_writedata = 32'hDEADBEEF; m_waitrequest = 1;
    wr_exp.push_back({20'h00010, 32'hDEADBEEF});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_write = 0;
      if (i == 3) m_waitrequest = 0;
      chk("wr_stall_mwrite", m_write, 1);
      chk("wr_stall_addr", m_address, 20'h00010);
      chk("wr_stall_data", m_writedata, 32'hDEADBEEF);
      chk("wr_stall_swait", s_waitrequest, 1);
    end
    @(negedge clk);
    chk("wr_done_mwrite", m_write, 0);
    chk("wr_done_swait", s_waitrequest, 0);

    // Five reads against a 4-deep pending limit.
    rsp_delay = 10; max_pend = 0;
    for (int i = 0; i < 5; i++) cmd(1, rd_addr[i], '0, rd_data[i], 0);
    wait_drain();
    chk("max_outstanding", max_pend, 4);

    // Idle freeze, then stray strobes while frozen.
    @(negedge clk); freeze_req = 1;
    @(negedge clk);
    chk("idle_freeze_ack_c1", freeze_ack, 0);
    chk("idle_freeze_swait", s_waitrequest, 1);
    @(negedge clk);
    chk("idle_freeze_ack_c2", freeze_ack, 1);
    act_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_read || m_write) act_cnt++;
      s_read = 1'($urandom_range(0, 1)); s_write = 1'($urandom_range(0, 1));
      s_address = 20'($urandom); s_writedata = $urandom;
    end
    @(negedge clk);
    s_read = 0; s_write = 0;
    if (m_read || m_write) act_cnt++;
    chk("frozen_activity", act_cnt, 0);
    chk("frozen_err", err_cnt, 0);
    chk("frozen_ack", freeze_ack, 1);
    freeze_req = 0;
    @(negedge clk);
    chk("unfreeze_ack", freeze_ack, 0);
    chk("unfreeze_swait", s_waitrequest, 0);

    // Freeze with two reads outstanding.
    rsp_delay = 8;
    cmd(1, 20'h00ABC, '0, 32'hC5A00ABC, 0);
    cmd(1, 20'h00DEF, '0, 32'hC5A00DEF, 0);
    freeze_req = 1;
    @(negedge clk); #4;
    chk("drain_swait", s_waitrequest, 1);
    chk("drain_ack", freeze_ack, 0);
    wait_ack("drain_ack_timeout");
    chk("drain_ack_timing", cyc, last_rdv_cyc + 2);
    chk("drain_forwarded", rd_exp.size(), 0);
    freeze_req = 0;
    @(negedge clk); #4;
    chk("drain_unfreeze_ack", freeze_ack, 0);
    chk("drain_unfreeze_swait", s_waitrequest, 0);

    // Freeze request dropped mid-drain still reaches FROZEN.
    rsp_delay = 6;
    cmd(1, 20'h01234, '0, 32'hC5A01234, 0);
    freeze_req = 1;
    @(negedge clk);
    freeze_req = 0;
    wait_ack("short_freeze_ack");
    @(negedge clk); #4;
    chk("short_freeze_release", freeze_ack, 0);
    wait_drain();

    // Dual strobe then a stray response.
    @(negedge clk); s_read = 1; s_write = 1;
    @(negedge clk); s_read = 0; s_write = 0;
    chk("dual_err", err_cnt, 1);
    chk("dual_mread", m_read, 0);
    chk("dual_mwrite", m_write, 0);
    chk("dual_swait", s_waitrequest, 0);
    stray = 1;
    @(negedge clk);
    chk("stray_err", err_cnt, 2);
    chk("stray_srdv_c1", s_readdatavalid, 0);
    @(negedge clk);
    chk("stray_srdv_c2", s_readdatavalid, 0);
    chk("stray_err_hold", err_cnt, 2);

    // Saturation.
    s_read = 1; s_write = 1;
    repeat (252) @(negedge clk);
    chk("err_254", err_cnt, 254);
    repeat (3) @(negedge clk);
    chk("err_sat", err_cnt, 255);
    s_read = 0; s_write = 0;

    // Reset during a stalled write with 3 reads outstanding.
    rsp_delay = 40;
    cmd(1, 20'h00111, '0, 32'hC5A00111, 0);
    cmd(1, 20'h00222, '0, 32'hC5A00222, 0);
    cmd(1, 20'h00333, '0, 32'hC5A00333, 0);
    cmd(0, 20'h00444, 32'h12345678, '0, 1);
    @(negedge clk);
    chk("pre_reset_stall", m_write, 1);
    rst = 0;
    rd_exp.delete();
    wr_exp.delete();
    @(negedge clk);
    check_reset_outputs("mid_reset");
    m_waitrequest = 0;
    rst = 1;
    wait_drain();
    chk("post_reset_err", err_cnt, 3);
    chk("post_reset_srdv", s_readdatavalid, 0);

    rsp_delay = 2;
    cmd(1, 20'h0BEEF, '0, 32'hC5A0BEEF, 0);
    wait_drain();
    chk("post_reset_err_final", err_cnt, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
